au_seq: RTL and testbench

Parametrised, registered successor to the 16-bit combinational add/sub unit. Accepts one operation per valid/ready handshake, computes add, subtract, add/sub-with-carry, compare and an iterative shift-add multiply on `W`-bit operands. Delivers a registered result with v/c/n/z flags and a stored carry flag for multi-word chaining. Sits between the datapath register file and the writeback stage.

---
 rtl/au_pkg.sv | 17 +
 rtl/au_addsub.sv | 27 ++
 rtl/au_seq.sv | 218 +++++++++++++++++++++
 tb/tb_au_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/au_pkg.sv
// au_pkg: opcode encodings and FSM state type shared by the au_seq block.
package au_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_ADC = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_CMP = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/au_addsub.sv
// au_addsub: combinational W-bit adder with carry-in and optional B inversion.
// Subtraction is formed as A + ~B + cin. Overflow is carry-into-MSB XOR carry-out.
module au_addsub #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         inv_b,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  logic [W-1:0] b_eff_s;
  logic [W:0]   full_s;
  logic [W-1:0] low_s;

  assign b_eff_s = inv_b ? ~b : b;
  assign full_s  = {1'b0, a} + {1'b0, b_eff_s} + {{W{1'b0}}, cin};
  // Sum of the bits below the MSB; its top bit is the carry into the MSB.
  assign low_s   = {1'b0, a[W-2:0]} + {1'b0, b_eff_s[W-2:0]} + {{(W-1){1'b0}}, cin};
  assign sum     = full_s[W-1:0];
  assign cout    = full_s[W];
  assign ovf     = low_s[W-1] ^ full_s[W];

endmodule

// File: rtl/au_seq.sv
// au_seq: registered add/sub/compare unit with valid/ready handshake and a
// stored carry (cq) for multi-word chaining. Defining AU_MUL_EN adds an
// iterative shift-add multiplier (opcode 5) with a BUSY state; without it
// opcode 5 is reported as illegal.
module au_seq
  import au_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         v,
  output logic         c,
  output logic         n,
  output logic         z,
  output logic         err
);

  localparam int CW = $clog2(W) + 1;

  state_t       state_r, state_nx;
  logic [W-1:0] res_r, res_nx;
  logic         v_r, v_nx, c_r, c_nx, n_r, n_nx, z_r, z_nx;
  logic         err_r, err_nx, cq_r, cq_nx;
  logic [W-1:0] add_a_s, add_b_s, add_sum_s;
  logic         add_cin_s, add_inv_s, add_cout_s, add_ovf_s;
  logic         ready_s, accept_s, legal_s;
`ifdef AU_MUL_EN
  logic [W-1:0]  a_r, a_nx, hi_r, hi_nx, lo_r, lo_nx;
  logic [CW-1:0] cnt_r, cnt_nx;
`endif

  assign ready_s  = (state_r == IDLE) || ((state_r == DONE) && out_ready);
  assign accept_s = in_valid && ready_s;

  // Decode which opcodes this build implements.
  always_comb begin
    legal_s = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_CMP: legal_s = 1'b1;
`ifdef AU_MUL_EN
      OP_MUL: legal_s = 1'b1;
`endif
      default: legal_s = 1'b0;
    endcase
  end

  // Steer the shared adder: request operands at accept, accumulate step in BUSY.
  always_comb begin
    add_a_s   = A;
    add_b_s   = B;
    add_cin_s = 1'b0;
    add_inv_s = 1'b0;
    case (op)
      OP_ADD: begin add_inv_s = 1'b0; add_cin_s = 1'b0; end
      OP_SUB, OP_CMP: begin add_inv_s = 1'b1; add_cin_s = 1'b1; end
      OP_ADC: begin add_inv_s = 1'b0; add_cin_s = cq_r; end
      OP_SBC: begin add_inv_s = 1'b1; add_cin_s = cq_r; end
      default: begin add_inv_s = 1'b0; add_cin_s = 1'b0; end
    endcase
`ifdef AU_MUL_EN
    if (state_r == BUSY) begin
      add_a_s   = hi_r;
      add_b_s   = lo_r[0] ? a_r : {W{1'b0}};
      add_cin_s = 1'b0;
      add_inv_s = 1'b0;
    end else begin
      add_a_s = A;
    end
`endif
  end

  au_addsub #(.W(W)) u_addsub (
    .a    (add_a_s),
    .b    (add_b_s),
    .cin  (add_cin_s),
    .inv_b(add_inv_s),
    .sum  (add_sum_s),
    .cout (add_cout_s),
    .ovf  (add_ovf_s)
  );

  // Next-state and next result/flag values.
  always_comb begin
    state_nx = state_r;
    res_nx   = res_r;
    v_nx     = v_r;
    c_nx     = c_r;
    n_nx     = n_r;
    z_nx     = z_r;
    err_nx   = err_r;
    cq_nx    = cq_r;
`ifdef AU_MUL_EN
    a_nx     = a_r;
    hi_nx    = hi_r;
    lo_nx    = lo_r;
    cnt_nx   = cnt_r;
`endif
    if (accept_s) begin
      if (!legal_s) begin
        state_nx = DONE;
        res_nx   = {W{1'b0}};
        {v_nx, c_nx, n_nx, z_nx} = 4'b0000;
        err_nx   = 1'b1;
`ifdef AU_MUL_EN
      end else if (op == OP_MUL) begin
        // Product register {hi, lo} starts as {0, B}; B is consumed LSB-first.
        state_nx = BUSY;
        a_nx     = A;
        hi_nx    = {W{1'b0}};
        lo_nx    = B;
        cnt_nx   = {CW{1'b0}};
`endif
      end else begin
        state_nx = DONE;
        res_nx   = (op == OP_CMP) ? {W{1'b0}} : add_sum_s;
        v_nx     = add_ovf_s;
        c_nx     = add_cout_s;
        n_nx     = add_sum_s[W-1] ^ add_ovf_s;
        z_nx     = (add_sum_s == {W{1'b0}});
        err_nx   = 1'b0;
        cq_nx    = add_cout_s;
      end
    end else begin
      case (state_r)
        IDLE: state_nx = IDLE;
`ifdef AU_MUL_EN
        BUSY: begin
          // Add partial product into hi, then shift the 2W+1 bit value right.
          hi_nx  = {add_cout_s, add_sum_s[W-1:1]};
          lo_nx  = {add_sum_s[0], lo_r[W-1:1]};
          cnt_nx = cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == CW'(W - 1)) begin
            state_nx = DONE;
            res_nx   = lo_nx;
            v_nx     = 1'b0;
            c_nx     = (hi_nx != {W{1'b0}});
            n_nx     = lo_nx[W-1];
            z_nx     = (lo_nx == {W{1'b0}});
            err_nx   = 1'b0;
            cq_nx    = (hi_nx != {W{1'b0}});
          end else begin
            state_nx = BUSY;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state_nx = IDLE;
          end else begin
            state_nx = DONE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Result, flag, stored-carry and multiplier datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_r <= {W{1'b0}};
      v_r   <= 1'b0;
      c_r   <= 1'b0;
      n_r   <= 1'b0;
      z_r   <= 1'b0;
      err_r <= 1'b0;
      cq_r  <= 1'b0;
`ifdef AU_MUL_EN
      a_r   <= {W{1'b0}};
      hi_r  <= {W{1'b0}};
      lo_r  <= {W{1'b0}};
      cnt_r <= {CW{1'b0}};
`endif
    end else begin
      res_r <= res_nx;
      v_r   <= v_nx;
      c_r   <= c_nx;
      n_r   <= n_nx;
      z_r   <= z_nx;
      err_r <= err_nx;
      cq_r  <= cq_nx;
`ifdef AU_MUL_EN
      a_r   <= a_nx;
      hi_r  <= hi_nx;
      lo_r  <= lo_nx;
      cnt_r <= cnt_nx;
`endif
    end
  end

  assign in_ready  = ready_s;
  assign out_valid = (state_r == DONE);
  assign res       = res_r;
  assign v         = v_r;
  assign c         = c_r;
  assign n         = n_r;
  assign z         = z_r;
  assign err       = err_r;

endmodule

// File: tb/tb_au_seq.sv
// tb_au_seq: self-checking bench for au_seq (W=16). Expected results come
// from an arithmetic model using exact integer sums and products.
module tb_au_seq;

  localparam int W = 16;
`ifdef AU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] A = 16'h0000;
  logic [W-1:0] B = 16'h0000;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] res;
  logic         v, c, n, z, err;

  int   errors = 0;
  int   checks = 0;
  logic cq_m = 1'b0;

  au_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .v(v), .c(c), .n(n), .z(z), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: exact integer arithmetic, packed as {res,v,c,n,z,err}.
  function automatic logic [20:0] model(input logic [2:0] o, input logic [15:0] a,
                                        input logic [15:0] b, input logic cqi,
                                        output logic cqo);
    longint ua, ub, sa, sb, uex, sex, p, bw;
    logic [15:0] r;
    logic fv, fc, fn, fz, fe;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    bw = 0; uex = 0; sex = 0; p = 0;
    r = 16'h0000; fv = 1'b0; fc = 1'b0; fn = 1'b0; fz = 1'b0; fe = 1'b0;
    cqo = cqi;
    case (o)
      3'd0, 3'd2: begin
        bw  = (o == 3'd2) ? longint'(cqi) : 0;
        uex = ua + ub + bw; sex = sa + sb + bw;
        fc  = (uex > 65535);
      end
      3'd1, 3'd3, 3'd4: begin
        bw  = (o == 3'd3) ? 1 - longint'(cqi) : 0;
        uex = ua - ub - bw; sex = sa - sb - bw;
        fc  = (ua >= ub + bw);
      end
`ifdef AU_MUL_EN
      3'd5: begin
        p   = ua * ub;
        uex = p;
        fc  = ((p >> 16) != 0);
      end
`endif
      default: fe = 1'b1;
    endcase
    if (!fe) begin
      r = uex[15:0];
      if (o == 3'd5) begin
        fv = 1'b0; fn = r[15];
      end else begin
        fv = (sex > 32767) || (sex < -32768);
        fn = (sex < 0);
      end
      fz  = (r == 16'h0000);
      if (o == 3'd4) r = 16'h0000;
      cqo = fc;
    end
    return {r, fv, fc, fn, fz, fe};
  endfunction

  // Issue one request with out_ready high; returns edges from accept to out_valid.
  task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output bit rdy_seen);
    int g;
    op = o; A = a; B = b; in_valid = 1'b1; out_ready = 1'b1; g = 0;
    while (!in_ready && g < 100) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); A = 16'($urandom); B = 16'($urandom);
    lat = 0; rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, res, v, c, n, z, err} !== {1'b1, 1'b0, 16'h0000, 5'b00000}) begin
      errors++;
      $display("FAIL reset: got rdy=%b ov=%b res=%h vcnz=%b%b%b%b err=%b want rdy=1 ov=0 res=0 flags=0",
               in_ready, out_valid, res, v, c, n, z, err);
    end
    rst = 1'b0;
    cq_m = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL idle_no_valid: got out_valid=%b want 0", out_valid);
    end
  endtask

  // Directed vectors plus random mix of every opcode, one at a time.
  task automatic test_ops();
    logic [2:0]  ot [6] = '{3'd0, 3'd1, 3'd4, 3'd6, 3'd7, 3'd5};
    logic [15:0] at [6] = '{16'h7FFF, 16'h0003, 16'h1234, 16'hAAAA, 16'h5555, 16'h0100};
    logic [15:0] bt [6] = '{16'h0001, 16'h0005, 16'h1234, 16'h1111, 16'h2222, 16'h0100};
    logic [2:0]  o;
    logic [15:0] a, b;
    logic [20:0] exp;
    logic        cqn;
    int          lat, lat_exp;
    bit          rdy;
    for (int i = 0; i < 46; i++) begin
      if (i < 6) begin o = ot[i]; a = at[i]; b = bt[i]; end
      else begin o = 3'($urandom_range(0, 7)); a = 16'($urandom); b = 16'($urandom); end
      if (i >= 6 && ($urandom_range(0, 3) == 0)) b = a;
      exp = model(o, a, b, cq_m, cqn);
      lat_exp = (MUL_EN && o == 3'd5) ? W : 0;
      run_op(o, a, b, lat, rdy);
      checks++;
      if ({res, v, c, n, z, err} !== exp || lat != lat_exp || rdy) begin
        errors++;
        $display("FAIL op%0d_%0d: A=%h B=%h got res=%h vcnz=%b%b%b%b err=%b lat=%0d rdy_busy=%b want res=%h vcnz=%b err=%b lat=%0d rdy_busy=0",
                 o, i, a, b, res, v, c, n, z, err, lat, rdy, exp[20:5], exp[4:1], exp[0], lat_exp);
      end
      cq_m = cqn;
      @(posedge clk); #1;
    end
  endtask

  // ADD with carry then ADC chained at one op per clock, then random single-cycle ops.
  task automatic test_back_to_back();
    logic [2:0]  o;
    logic [15:0] a, b;
    logic [20:0] exp;
    logic        cqn;
    for (int i = 0; i < 24; i++) begin
      if (i == 0) begin o = 3'd0; a = 16'hFFFF; b = 16'h0001; end
      else if (i == 1) begin o = 3'd2; a = 16'h0000; b = 16'h0000; end
      else begin o = 3'($urandom_range(0, 4)); a = 16'($urandom); b = 16'($urandom); end
      exp = model(o, a, b, cq_m, cqn);
      op = o; A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready_%0d: got in_ready=%b want 1", i, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, res, v, c, n, z, err} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL b2b_%0d: op=%0d A=%h B=%h got ov=%b res=%h vcnz=%b%b%b%b err=%b want ov=1 res=%h vcnz=%b err=%b",
                 i, o, a, b, out_valid, res, v, c, n, z, err, exp[20:5], exp[4:1], exp[0]);
      end
      cq_m = cqn;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Result held under backpressure; a pending request is not taken.
  task automatic test_backpressure();
    logic [15:0] a, b;
    logic [20:0] exp;
    logic        cqn;
    a = 16'($urandom); b = 16'($urandom);
    exp = model(3'd1, a, b, cq_m, cqn);
    op = 3'd1; A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    op = 3'd0; A = 16'($urandom); B = 16'($urandom);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({out_valid, in_ready, res, v, c, n, z, err} !== {2'b10, exp}) begin
        errors++;
        $display("FAIL backpressure_%0d: got ov=%b rdy=%b res=%h vcnz=%b%b%b%b err=%b want ov=1 rdy=0 res=%h vcnz=%b err=%b",
                 k, out_valid, in_ready, res, v, c, n, z, err, exp[20:5], exp[4:1], exp[0]);
      end
      @(posedge clk); #1;
    end
    cq_m = cqn;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL backpressure_release: got out_valid=%b want 0", out_valid);
    end
  endtask

  // Illegal op between a carry-producing ADD and an ADC must leave cq intact.
  task automatic test_illegal_keeps_cq();
    logic [2:0]  ot [3] = '{3'd0, 3'd6, 3'd2};
    logic [15:0] at [3] = '{16'hFFFF, 16'h1234, 16'h0000};
    logic [15:0] bt [3] = '{16'h0001, 16'h4321, 16'h0000};
    logic [20:0] exp;
    logic        cqn;
    int          lat;
    bit          rdy;
    for (int i = 0; i < 3; i++) begin
      exp = model(ot[i], at[i], bt[i], cq_m, cqn);
      run_op(ot[i], at[i], bt[i], lat, rdy);
      checks++;
      if ({res, v, c, n, z, err} !== exp || lat != 0) begin
        errors++;
        $display("FAIL illegal_cq_%0d: got res=%h vcnz=%b%b%b%b err=%b lat=%0d want res=%h vcnz=%b err=%b lat=0",
                 i, res, v, c, n, z, err, lat, exp[20:5], exp[4:1], exp[0]);
      end
      cq_m = cqn;
    end
    @(posedge clk); #1;
  endtask

  // Reset while an operation is in flight: no result, reset values, cq cleared.
  task automatic test_rst_mid_op();
    logic [20:0] exp;
    logic        cqn;
    int          lat;
    bit          rdy, seen;
    op = MUL_EN ? 3'd5 : 3'd0; A = 16'h0100; B = 16'h0101;
    in_valid = 1'b1; out_ready = MUL_EN ? 1'b1 : 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, res, v, c, n, z, err} !== {1'b1, 1'b0, 16'h0000, 5'b00000}) begin
      errors++;
      $display("FAIL rst_mid_op: got rdy=%b ov=%b res=%h vcnz=%b%b%b%b err=%b want rdy=1 ov=0 res=0 flags=0",
               in_ready, out_valid, res, v, c, n, z, err);
    end
    rst = 1'b0; out_ready = 1'b1; cq_m = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL rst_no_result: got out_valid=1 after reset want 0");
    end
    exp = model(3'd2, 16'h0000, 16'h0000, cq_m, cqn);
    run_op(3'd2, 16'h0000, 16'h0000, lat, rdy);
    checks++;
    if ({res, v, c, n, z, err} !== exp) begin
      errors++;
      $display("FAIL rst_cq_cleared: got res=%h vcnz=%b%b%b%b want res=%h vcnz=%b",
               res, v, c, n, z, exp[20:5], exp[4:1]);
    end
    cq_m = cqn;
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_illegal_keeps_cq();
    test_rst_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
